// File: rtl/uart_tx_fifo_reader.sv
// uart_tx_fifo_reader: UART transmitter that drains a TX FIFO.
// Pops a word whenever the FIFO is non-empty and the transmitter is free,
// then sends start bit, DBIT data bits LSB first and a stop period, timed
// by an oversampling baud tick.
module uart_tx_fifo_reader #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int OVS     = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            en,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_r_data,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int SMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int SW   = (SMAX > 2) ? $clog2(SMAX) : 1;

  localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVS - 1);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [2:0]    N_LAST      = 3'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state, state_n;
  logic [SW-1:0]   s, s_n;
  logic [2:0]      n, n_n;
  logic [DBIT-1:0] b, b_n;
  logic            can_pop;

  // A pop needs an enabled transmitter, a word in the FIFO and reset released;
  // the reset term keeps the Mealy strobe quiet while reset_n is held low.
  assign can_pop = en && !fifo_empty && reset_n;

  assign tx_busy = (state != IDLE);

  // State and datapath registers; async reset aborts any frame in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      b     <= '0;
    end else begin
      state <= state_n;
      s     <= s_n;
      n     <= n_n;
      b     <= b_n;
    end
  end

  // Next-state, counter updates and Mealy outputs (pop strobe, done tick, tx).
  always_comb begin
    state_n      = state;
    s_n          = s;
    n_n          = n;
    b_n          = b;
    fifo_rd      = 1'b0;
    tx_done_tick = 1'b0;
    tx           = 1'b1;
    case (state)
      IDLE: begin
        if (can_pop) begin
          fifo_rd = 1'b1;
          b_n     = fifo_r_data;
          s_n     = '0;
          state_n = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (s_tick) begin
          if (s == S_BIT_LAST) begin
            s_n     = '0;
            n_n     = '0;
            state_n = DATA;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      DATA: begin
        tx = b[0];
        if (s_tick) begin
          if (s == S_BIT_LAST) begin
            s_n = '0;
            b_n = b >> 1;
            if (n == N_LAST) begin
              state_n = STOP;
            end else begin
              n_n = n + 1'b1;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s == S_STOP_LAST) begin
            tx_done_tick = 1'b1;
            s_n          = '0;
            // Chain straight into the next start bit when a word is waiting.
            if (can_pop) begin
              fifo_rd = 1'b1;
              b_n     = fifo_r_data;
              state_n = START;
            end else begin
              state_n = IDLE;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: doc/uart_tx_fifo_reader.md
Name: uart_tx_fifo_reader

Overview:
- Transmit end of the UART path: the read-side consumer of a FIFO built on the team's pointer-based FIFO controller.
- Pops one word from the FIFO whenever the FIFO is non-empty and the transmitter is free.
- Serialises each word as an asynchronous start/data/stop frame, timed by an external oversampling baud tick.
- Sits between the TX FIFO (register file plus controller) and the tx pin.

Parameters:
DBIT, 8, data bits per frame; legal 5..8
SB_TICK, 16, s_tick count for the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2)
OVS, 16, s_tick count per start or data bit

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
s_tick  input  1  baud tick, one-cycle pulse at OVS x baud rate
en  input  1  transmit enable; gates new pops only
fifo_empty  input  1  FIFO empty flag
fifo_r_data  input  DBIT  FIFO head word; combinationally valid whenever fifo_empty=0
fifo_rd  output  1  pop strobe to FIFO controller rd; one cycle per word
tx  output  1  serial line, idles high
tx_busy  output  1  high while a frame is in progress
tx_done_tick  output  1  one-cycle pulse at end of each stop period

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; tick counter s=0; bit counter n=0; shift register b=0.
  - tx=1, fifo_rd=0, tx_busy=0, tx_done_tick=0.
  - A frame in flight is aborted; tx returns high without waiting for a clock edge. No pop occurs during reset.
- FSM states: IDLE, START, DATA, STOP.
- tx_busy = (state != IDLE), registered state decode.
- IDLE:
  - tx=1; s_tick is ignored.
  - If en=1 and fifo_empty=0: in that same cycle fifo_rd=1 (Mealy), b<=fifo_r_data, s<=0, next=START.
  - Pop-to-start latency is 0 cycles; the tx falling edge appears on the following clock edge.
- START:
  - tx=0.
  - On s_tick: if s==OVS-1 then s<=0, n<=0, next=DATA; else s<=s+1.
- DATA:
  - tx=b[0], LSB first.
  - On s_tick with s==OVS-1: s<=0, b<=b>>1; if n==DBIT-1 then next=STOP, else n<=n+1.
  - On s_tick with s<OVS-1: s<=s+1.
- STOP:
  - tx=1.
  - On s_tick with s==SB_TICK-1: tx_done_tick=1 for that cycle (Mealy).
  - Then, if en=1 and fifo_empty=0: same cycle fifo_rd=1, b<=fifo_r_data, s<=0, next=START. This gives back-to-back frames with no idle gap.
  - Otherwise next=IDLE.
- Frame length is exactly (1+DBIT)*OVS + SB_TICK ticks.
- Counter widths: s wide enough for max(OVS, SB_TICK)-1; n is 3 bits. Counters change only on s_tick or on a state entry.
- Pop rules:
  - fifo_rd is never asserted while fifo_empty=1.
  - fifo_rd is asserted at most once per frame, only in IDLE or on the final STOP tick.
- en=0 mid-frame: the current frame completes unchanged; no further pop.
- A word changing on fifo_r_data after the pop cycle does not affect the frame, because b holds the latched copy.
- s_tick continuously high is legal: each clock counts as one tick.

Test Plan:
- Reset check: hold reset_n=0 with fifo_empty=0, en=1 -> tx=1, fifo_rd=0, tx_busy=0, tx_done_tick=0.
- Single word, s_tick=1 constant, DBIT=8, SB_TICK=16: load 0xA5 with fifo_empty falling at cycle 0 -> fifo_rd high in cycle 0 only; tx is 0 for 16 clocks, then bits 1,0,1,0,0,1,0,1 for 16 clocks each, then 1 for 16; tx_done_tick in cycle 160; tx_busy low from cycle 161.
- Back-to-back: FIFO holds 0x00 then 0xFF -> second fifo_rd coincides with the first tx_done_tick; the start bit of frame 2 begins on the next clock with no high gap; exactly 2 pops total.
- Empty FIFO: fifo_empty=1 for 1000 cycles with s_tick toggling -> fifo_rd never asserted, tx=1, tx_busy=0.
- Enable gating: deassert en during data bit 3 of 0x3C with the FIFO non-empty -> the frame completes correctly, no pop at the STOP end, state returns to IDLE; re-asserting en pops the next word.
- Reset mid-frame: pulse reset_n low during data bit 5, asynchronously between clock edges -> tx=1 immediately; after release, the next pop starts a fresh full frame with no partial bits.
